stream_mux_rr: RTL and testbench

//  Parametrised N:1 stream multiplexer with valid/ready handshake and a registered output.
//  Two select modes: manual (external sel, like a plain mux) and round-robin arbitration.

---
 rtl/stream_mux_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 52 +++++
 rtl/stream_mux_rr.sv | 124 ++++++++++++
 tb/tb_stream_mux_rr.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream multiplexer: select modes and index-width helper.
package stream_mux_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,  // manual channel select via sel
    MODE_RR  = 1'b1   // round-robin arbitration over valid channels
  } mode_e;

  // Width of a channel index; a 1- or 2-entry space still needs one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests so the search starts one
// past ptr, take the lowest set bit, then map it back to a real channel index.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int N     = 8,
  localparam int SEL_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     gnt_onehot,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  int         start;
  int         pos;
  int         idx;
  logic [N-1:0] rot;

  // Rotate: rot[i] is the request i positions after ptr (wrapping modulo N).
  always_comb begin
    start = (int'(ptr) >= N - 1) ? 0 : int'(ptr) + 1;
    rot   = '0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = i + start;
      if (j >= N) j = j - N;
      rot[i] = req[j];
    end
  end

  // Priority-encode the rotated vector (lowest position wins) and un-rotate.
  always_comb begin
    gnt_any = 1'b0;
    pos     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        gnt_any = 1'b1;
        pos     = i;
      end
    end
    idx = pos + start;
    if (idx >= N) idx = idx - N;
    gnt_idx    = SEL_W'(idx);
    gnt_onehot = '0;
    for (int k = 0; k < N; k++) begin
      gnt_onehot[k] = gnt_any && (k == idx);
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream mux with a registered output stage. Channel choice is
// either an external index (manual) or round-robin over the valid channels.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int N_CH  = 8,
  parameter  int WIDTH = 8,
  localparam int SEL_W = idx_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  input  logic                  out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_ch_q,    out_ch_d;
  logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

  logic [N_CH-1:0]  rr_oh;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_any;

  logic [N_CH-1:0]  sel_oh;
  logic             sel_any;

  logic [N_CH-1:0]  gnt_oh;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_any;
  logic [WIDTH-1:0] gnt_data;
  logic             load_en;

  rr_arbiter #(.N(N_CH)) u_arb (
    .req        (in_valid),
    .ptr        (rr_ptr_q),
    .gnt_onehot (rr_oh),
    .gnt_idx    (rr_idx),
    .gnt_any    (rr_any)
  );

  // Manual select: an out-of-range index matches no channel, so it never grants.
  always_comb begin
    sel_oh = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (int'(sel) == k) sel_oh[k] = in_valid[k];
    end
    sel_any = |sel_oh;
  end

  // Mode mux; mode/sel changes act on this cycle's grant only.
  always_comb begin
    if (mode == MODE_RR) begin
      gnt_oh  = rr_oh;
      gnt_idx = rr_idx;
      gnt_any = rr_any;
    end else begin
      gnt_oh  = sel_oh;
      gnt_idx = sel == '0 ? '0 : sel;
      gnt_any = sel_any;
    end
  end

  // Granted word via one-hot AND-OR.
  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (gnt_oh[k]) gnt_data = gnt_data | in_data[k*WIDTH +: WIDTH];
    end
  end

  // Output slot can take a word when empty or being drained this cycle.
  // in_ready is forced low during reset since the empty slot would otherwise accept.
  always_comb begin
    load_en  = !out_valid_q || out_ready;
    in_ready = (rst_n && load_en) ? gnt_oh : '0;
  end

  // Next state: load on transfer, bubble on idle, hold under backpressure.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      if (gnt_any) begin
        out_valid_d = 1'b1;
        out_data_d  = gnt_data;
        out_ch_d    = gnt_idx;
        if (mode == MODE_RR) rr_ptr_d = gnt_idx;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Output register and round-robin pointer; pointer resets to last channel so
  // the first round-robin grant searches from channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= SEL_W'(N_CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: directed scenario tasks plus a cycle model that
// predicts in_ready and queues expected output words for the scoreboard.
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode;
  logic [2:0]  sel;
  logic [7:0]  in_valid;
  logic [63:0] in_data;
  logic [7:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [2:0]  out_ch;
  logic        out_ready;

  logic        mode6;
  logic [2:0]  sel6;
  logic [5:0]  in_valid6;
  logic [47:0] in_data6;
  logic [5:0]  in_ready6;
  logic        out_valid6;
  logic [7:0]  out_data6;
  logic [2:0]  out_ch6;
  logic        out_ready6;

  int n_checks = 0;
  int n_pass   = 0;

  // scoreboard / model state
  logic [10:0] sbq[$];
  logic        m_ov;
  int          m_ptr;
  logic        sb_en = 1'b0;

  always #5 clk = ~clk;

  stream_mux_rr #(.N_CH(8), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  stream_mux_rr #(.N_CH(6), .WIDTH(8)) dut6 (
    .clk(clk), .rst_n(rst_n), .mode(mode6), .sel(sel6),
    .in_valid(in_valid6), .in_data(in_data6), .in_ready(in_ready6),
    .out_valid(out_valid6), .out_data(out_data6), .out_ch(out_ch6),
    .out_ready(out_ready6)
  );

  // Cycle model: checks current outputs, predicts this cycle's grant, advances.
  always @(negedge clk) begin
    if (rst_n && sb_en) begin
      logic        le, g_any;
      int          g;
      logic [7:0]  exp_rdy;
      logic [10:0] e;
      n_checks++;
      if (out_valid !== m_ov) $display("FAIL sb_valid got %b exp %b", out_valid, m_ov);
      else n_pass++;
      if (m_ov && out_ready) begin
        n_checks++;
        if (sbq.size() == 0) $display("FAIL sb_underflow out_ch=%0d", out_ch);
        else begin
          e = sbq.pop_front();
          if ({out_ch, out_data} !== e)
            $display("FAIL sb_word got ch%0d/%h exp ch%0d/%h", out_ch, out_data, e[10:8], e[7:0]);
          else n_pass++;
        end
      end
      le = !m_ov || out_ready;
      g_any = 1'b0; g = 0;
      if (mode == 1'b0) begin
        if (in_valid[sel]) begin g_any = 1'b1; g = int'(sel); end
      end else begin
        for (int i = 1; i <= 8; i++) begin
          int j;
          j = (m_ptr + i) % 8;
          if (!g_any && in_valid[j]) begin g_any = 1'b1; g = j; end
        end
      end
      exp_rdy = 8'h00;
      if (le && g_any) exp_rdy[g] = 1'b1;
      n_checks++;
      if (in_ready !== exp_rdy) $display("FAIL sb_in_ready got %h exp %h", in_ready, exp_rdy);
      else n_pass++;
      if (le) begin
        if (g_any) sbq.push_back({3'(g), in_data[g*8 +: 8]});
        m_ov = g_any;
        if (g_any && mode == 1'b1) m_ptr = g;
      end
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    sbq.delete();
    m_ov  = 1'b0;
    m_ptr = 7;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    mode = 1'b0; sel = 3'd2; in_valid = 8'hFF; out_ready = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL rst_pre_valid got %b exp 1", out_valid);
    else n_pass++;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_data, out_ch, in_ready} !== 20'h0)
      $display("FAIL rst_async got v%b d%h c%0d r%h exp all zero", out_valid, out_data, out_ch, in_ready);
    else n_pass++;
    apply_reset();
  endtask

  task automatic test_sel();
    mode = 1'b0; sel = 3'd3; in_valid = 8'hFF; out_ready = 1'b1;
    in_data[3*8 +: 8] = 8'hA5;
    #1;
    n_checks++;
    if (in_ready !== 8'h08) $display("FAIL sel_ready got %h exp 08", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, out_data, out_ch} !== {1'b1, 8'hA5, 3'd3})
      $display("FAIL sel_out got v%b d%h c%0d exp v1 da5 c3", out_valid, out_data, out_ch);
    else n_pass++;
    in_data[3*8 +: 8] = 8'h13;
  endtask

  task automatic test_rr_all();
    mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, out_ch, out_data} !== {1'b1, 3'(i % 8), 8'(8'h10 + i % 8)})
        $display("FAIL rr_seq[%0d] got v%b c%0d d%h exp v1 c%0d", i, out_valid, out_ch, out_data, i % 8);
      else n_pass++;
    end
  endtask

  task automatic test_rr_wrap();
    int exp_ch[4] = '{1, 7, 1, 7};
    in_valid = 8'b1000_0010;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, out_ch} !== {1'b1, 3'(exp_ch[i])})
        $display("FAIL rr_wrap[%0d] got v%b c%0d exp v1 c%0d", i, out_valid, out_ch, exp_ch[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] hd;
    logic [2:0] hc;
    in_valid = 8'hFF; out_ready = 1'b0;
    hd = out_data; hc = out_ch;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if ({in_ready, out_valid, out_data, out_ch} !== {8'h00, 1'b1, hd, hc})
        $display("FAIL bp_hold[%0d] got r%h v%b d%h c%0d exp r00 v1 d%h c%0d",
                 i, in_ready, out_valid, out_data, out_ch, hd, hc);
      else n_pass++;
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_ch !== 3'(( int'(hc) + 1) % 8))
      $display("FAIL bp_resume got c%0d exp c%0d", out_ch, (int'(hc) + 1) % 8);
    else n_pass++;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_idle_sel();
    mode = 1'b0; sel = 3'd5; in_valid = 8'hDF; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, in_ready} !== 9'h0) $display("FAIL idle_sel got v%b r%h exp v0 r00", out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_sel_oob();
    mode6 = 1'b0; sel6 = 3'd7; in_valid6 = 6'h3F; out_ready6 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid6, in_ready6} !== 7'h0)
        $display("FAIL sel_oob[%0d] got v%b r%h exp v0 r00", i, out_valid6, in_ready6);
      else n_pass++;
    end
  endtask

  initial begin
    mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0;
    for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = 8'(8'h10 + k);
    mode6 = 1'b0; sel6 = '0; in_valid6 = '0; out_ready6 = 1'b0;
    for (int k = 0; k < 6; k++) in_data6[k*8 +: 8] = 8'(8'h10 + k);
    apply_reset();
    sb_en = 1'b1;
    test_reset();
    test_sel();
    test_rr_all();
    test_rr_wrap();
    test_backpressure();
    test_idle_sel();
    test_sel_oob();
    sb_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
